// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory arbiter slice.
package dmem_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef enum logic {RUN, CLEAR} arb_state_t;
  typedef enum logic {PORT_A, PORT_B} port_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, clear-control and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if;
  import dmem_pkg::*;

  logic              A_req, B_req;
  logic              A_wr, B_wr;
  logic [ADDR_W-1:0] A_addr, B_addr;
  logic [DATA_W-1:0] A_wdata, B_wdata;
  logic              A_gnt, B_gnt;
  logic              A_rvalid, B_rvalid;
  logic [DATA_W-1:0] R_data;
  logic              Clr;
  logic              Busy;
  logic [ADDR_W-1:0] M_addr;
  logic [DATA_W-1:0] M_wdata;
  logic              M_wr;
  logic [DATA_W-1:0] M_rdata;

  modport arb (
    input  A_req, B_req, A_wr, B_wr, A_addr, B_addr, A_wdata, B_wdata, Clr, M_rdata,
    output A_gnt, B_gnt, A_rvalid, B_rvalid, R_data, Busy, M_addr, M_wdata, M_wr
  );

  modport host (
    output A_req, B_req, A_wr, B_wr, A_addr, B_addr, A_wdata, B_wdata, Clr, M_rdata,
    input  A_gnt, B_gnt, A_rvalid, B_rvalid, R_data, Busy, M_addr, M_wdata, M_wr
  );

endinterface

// File: rtl/dmem_clear_seq.sv
// Zero-fill address counter; done_c marks the last word of a sweep.
module dmem_clear_seq
  import dmem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] count,
  output logic              done_c
);

  assign done_c = en && (count == ADDR_W'(DEPTH - 1));

  // Counter parks at zero whenever the sweep is not running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!en || done_c) begin
      count <= '0;
    end else begin
      count <= count + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter in front of the single-port data memory.
// Optional zero-fill sequencer is built when DMEM_ARB_CLEAR_EN is defined.
module dmem_arbiter
  import dmem_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset_n,
  dmem_arbiter_if.arb bus
);

  arb_state_t        state, next_state;
  port_t             prio;
  logic [ADDR_W-1:0] addr_q, clr_cnt;
  logic [DATA_W-1:0] wdata_q;
  logic              clr_done;
  logic              a_gnt, b_gnt;
  logic              a_rvalid, b_rvalid;

`ifdef DMEM_ARB_CLEAR_EN
  dmem_clear_seq u_clear_seq (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .en     (state == CLEAR),
    .count  (clr_cnt),
    .done_c (clr_done)
  );

  // Reset lands in CLEAR so every reset release zero-fills the memory.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= CLEAR;
    else          state <= next_state;
  end
`else
  logic [1:0] unused_nc;
  assign unused_nc = {bus.Clr, next_state == CLEAR};
  assign clr_cnt   = '0;
  assign clr_done  = 1'b0;
  assign state     = RUN;
`endif

  // Grant selection, memory-side mux and next state.
  always_comb begin
    next_state  = state;
    a_gnt       = 1'b0;
    b_gnt       = 1'b0;
    bus.M_addr  = addr_q;
    bus.M_wdata = wdata_q;
    bus.M_wr    = 1'b0;
    case (state)
      RUN: begin
        if (Reset_n) begin
          if (bus.A_req && (!bus.B_req || prio == PORT_A)) a_gnt = 1'b1;
          else if (bus.B_req)                                b_gnt = 1'b1;
        end
        if (a_gnt) begin
          bus.M_addr  = bus.A_addr;
          bus.M_wdata = bus.A_wdata;
          bus.M_wr    = bus.A_wr;
        end else if (b_gnt) begin
          bus.M_addr  = bus.B_addr;
          bus.M_wdata = bus.B_wdata;
          bus.M_wr    = bus.B_wr;
        end
`ifdef DMEM_ARB_CLEAR_EN
        if (Reset_n && bus.Clr) next_state = CLEAR;
`endif
      end
      CLEAR: begin
        bus.M_addr  = clr_cnt;
        bus.M_wdata = '0;
        bus.M_wr    = Reset_n;
        if (clr_done) next_state = RUN;
      end
      default: next_state = RUN;
    endcase
  end

  // Priority, held bus values and read-valid strobes.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      prio     <= PORT_A;
      addr_q   <= '0;
      wdata_q  <= '0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      if (a_gnt)      prio <= PORT_B;
      else if (b_gnt) prio <= PORT_A;
      addr_q   <= bus.M_addr;
      wdata_q  <= bus.M_wdata;
      a_rvalid <= a_gnt & ~bus.A_wr;
      b_rvalid <= b_gnt & ~bus.B_wr;
    end
  end

  assign bus.A_gnt    = a_gnt;
  assign bus.B_gnt    = b_gnt;
  assign bus.A_rvalid = a_rvalid;
  assign bus.B_rvalid = b_rvalid;
  assign bus.R_data   = bus.M_rdata;
  assign bus.Busy     = (state == CLEAR);

endmodule
